// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store request at a time, performs
// a word read or byte-masked write after WAIT_CYCLES wait states, and holds
// the response until the initiator takes it.
module dmem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_nxt;

    logic [3:0]        cnt;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;
    logic [3:0]        cap_wstrb;

    logic [31:0]       mem [DEPTH_WORDS];

    logic [ADDR_W-1:0] word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              acc_err;
    logic              do_access;

    // Word index zero-extended to the address width so the range check
    // compares against DEPTH_WORDS at full precision.
    assign word_idx  = {2'b00, cap_addr[ADDR_W-1:2]};
    assign mem_idx   = word_idx[IDX_W-1:0];
    assign acc_err   = (cap_addr[1:0] != 2'b00) || (word_idx >= ADDR_W'(DEPTH_WORDS));
    assign do_access = (state == WAIT) && (cnt == 4'd0);
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: IDLE -> WAIT -> RESP -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid)     state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0)   state_nxt = RESP;
            RESP:    if (rsp_ready)     state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Request capture, wait counter and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_wstrb <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_wstrb <= req_wstrb;
                cnt       <= 4'(WAIT_CYCLES);
            end
            if (state == WAIT && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (do_access) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (!acc_err && !cap_we) ? mem[mem_idx] : '0;
            end
            if (state == RESP && rsp_ready) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end

    // Byte-masked RAM write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (do_access && !acc_err && cap_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (cap_wstrb[i])
                    mem[mem_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (0 and 3 wait states)
// driven with directed and random requests, checked against a word-array model.
module tb_dmem_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wstrb [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    typedef struct {
        int          acc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mm [2][DEPTH];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          stall [2];
    bit          bp_rand [2];
    bit          outst [2];
    bit          prev_v [2];
    int          wc [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[inst %0d] @cyc %0d: got %h want %h", name, k, cyc, act, exp);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    // Reference model: compute the response and apply the store at issue time
    task automatic model_req(input int k, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb, output exp_t e);
        longint unsigned w = longint'(addr) / 4;
        e.err   = (addr % 4 != 0) || (w >= DEPTH);
        e.rdata = 32'h0;
        if (!e.err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) mm[k][w][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                e.rdata = mm[k][w];
            end
        end
    endtask

    // Drive one request; wait (bounded) for acceptance and queue the expectation
    task automatic issue(input int k, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wdata; req_wstrb[k] = strb;
        req_valid[k] = 1'b1;
        while (!req_ready[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[k]) begin
            check("accept_timeout", k, 32'd0, 32'd1);
            req_valid[k] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        outst[k] = 1'b1;
        model_req(k, we, addr, wdata, strb, e);
        e.acc = cyc;
        if (k == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (outst[k] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (outst[k]) check("drain_timeout", k, 32'd0, 32'd1);
    endtask

    // Monitor: compares every presented response against the queue head
    task automatic mon(input int k);
        exp_t e;
        if (rst[k]) begin
            prev_v[k] = 1'b0;
            return;
        end
        check("req_ready", k, 32'(req_ready[k]), 32'(!outst[k]));
        if (rsp_valid[k]) begin
            if (qsize(k) == 0) begin
                check("unexpected_rsp", k, 32'd1, 32'd0);
            end else begin
                e = (k == 0) ? q0[0] : q1[0];
                if (!prev_v[k]) check("latency", k, 32'(cyc - e.acc), 32'(1 + wc[k]));
                check("rdata", k, rsp_rdata[k], e.rdata);
                check("err", k, 32'(rsp_err[k]), 32'(e.err));
                if (rsp_ready[k]) begin
                    if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    outst[k] = 1'b0;
                end
            end
        end
        prev_v[k] = rsp_valid[k];
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) mon(k);
    end

    // Response backpressure: forced stalls take priority over random gaps
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (stall[k] > 0) begin
                rsp_ready[k] = 1'b0;
                if (rsp_valid[k]) stall[k]--;
            end else begin
                rsp_ready[k] = bp_rand[k] ? ($urandom % 3 != 0) : 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   n;
        logic [31:0] a;
        wc[0] = 0; wc[1] = 3;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
            req_wdata[k] = '0; req_wstrb[k] = '0; rsp_ready[k] = 1'b1;
            stall[k] = 0; bp_rand[k] = 1'b0; outst[k] = 1'b0; prev_v[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
            check("rst_rdata", k, rsp_rdata[k], 32'd0);
            check("rst_err", k, 32'(rsp_err[k]), 32'd0);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("ready_after_rst", k, 32'(req_ready[k]), 32'd1);

        // Give the model a defined value for every word the bench reads
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 16; w++) issue(k, 1'b1, 32'(w * 4), $urandom, 4'hF);
            issue(k, 1'b1, 32'((DEPTH - 1) * 4), $urandom, 4'hF);
        end

        for (int k = 0; k < 2; k++) begin
            // Store then load
            issue(k, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
            issue(k, 1'b0, 32'h10, 32'h0, 4'h0);
            // Byte strobes
            issue(k, 1'b1, 32'h10, 32'h11223344, 4'hF);
            issue(k, 1'b1, 32'h10, 32'hAABBCCDD, 4'h5);
            issue(k, 1'b0, 32'h10, 32'h0, 4'h0);
            // Zero-strobe store: no change, no error
            issue(k, 1'b1, 32'h10, 32'h55555555, 4'h0);
            issue(k, 1'b0, 32'h10, 32'h0, 4'h0);
            // Errors, then neighbouring words
            issue(k, 1'b0, 32'h13, 32'h0, 4'h0);
            issue(k, 1'b1, 32'(DEPTH * 4), 32'hFFFFFFFF, 4'hF);
            issue(k, 1'b1, 32'h0E, 32'hFFFFFFFF, 4'hF);
            issue(k, 1'b0, 32'h0C, 32'h0, 4'h0);
            issue(k, 1'b0, 32'h10, 32'h0, 4'h0);
            issue(k, 1'b0, 32'h14, 32'h0, 4'h0);
            issue(k, 1'b0, 32'((DEPTH - 1) * 4), 32'h0, 4'h0);
        end

        // Wait states with a 5-cycle response stall
        stall[1] = 5;
        issue(1, 1'b0, 32'h10, 32'h0, 4'h0);
        wait_idle(1);

        // Reset during WAIT of a store to 0x20
        issue(1, 1'b1, 32'h20, 32'h0, 4'hF);
        wait_idle(1);
        @(negedge clk);
        req_we[1] = 1'b1; req_addr[1] = 32'h20; req_wdata[1] = 32'hCAFEF00D; req_wstrb[1] = 4'hF;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        outst[1] = 1'b1;
        @(posedge clk);
        #1;
        rst[1] = 1'b1;
        #1;
        check("abort_rsp_valid", 1, 32'(rsp_valid[1]), 32'd0);
        outst[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst[1] = 1'b0;
        @(negedge clk);
        check("abort_ready", 1, 32'(req_ready[1]), 32'd1);
        issue(1, 1'b0, 32'h20, 32'h0, 4'h0);

        // Store pulsed during RESP must be ignored
        for (int k = 0; k < 2; k++) begin
            stall[k] = 4;
            issue(k, 1'b0, 32'h8, 32'h0, 4'h0);
            n = 0;
            while (!rsp_valid[k] && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("resp_reached", k, 32'(rsp_valid[k]), 32'd1);
            req_we[k] = 1'b1; req_addr[k] = 32'h8; req_wdata[k] = 32'h0BADF00D; req_wstrb[k] = 4'hF;
            req_valid[k] = 1'b1;
            repeat (2) @(negedge clk);
            req_valid[k] = 1'b0;
            wait_idle(k);
            issue(k, 1'b0, 32'h8, 32'h0, 4'h0);
        end

        // Random traffic with random backpressure
        bp_rand[0] = 1'b1; bp_rand[1] = 1'b1;
        for (int i = 0; i < 80; i++) begin
            int k = i % 2;
            int r = $urandom % 10;
            if (r == 0)      a = 32'(($urandom % 16) * 4 + 1 + $urandom % 3);
            else if (r == 1) a = 32'((DEPTH + $urandom % 64) * 4);
            else             a = 32'(($urandom % 16) * 4);
            issue(k, 1'($urandom), a, $urandom, 4'($urandom));
        end
        bp_rand[0] = 1'b0; bp_rand[1] = 1'b0;
        wait_idle(0);
        wait_idle(1);
        check("q0_empty", 0, 32'(q0.size()), 32'd0);
        check("q1_empty", 1, 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
